redundancy_pair_scanner: RTL and testbench
==========================================

# redundancy_pair_scanner

Scans a loaded kernel of weights for pairs of equal, non-zero values and emits each pair's index pair (idx1 < idx2) through a valid/ready handshake. It sits directly upstream of the distance calculator, which turns each emitted (idx1, idx2) into a reuse distance. One kernel is scanned per start pulse, one candidate pair per cycle.

## Interface
- WORD_WIDTH, 8: width of weights, indices and klen; matches the distance calculator's index width.
- MAX_KLEN, 16: weight buffer depth, i.e. the maximum kernel element count (fw × kernel height).
- ADDR_WIDTH, $clog2(MAX_KLEN): width of the weight buffer write address.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- w_we  in  1  weight buffer write enable.
- w_addr  in  ADDR_WIDTH  weight buffer write address.
- w_data  in  WORD_WIDTH  weight value to write.
- start  in  1  begin a scan; sampled only in IDLE.
- klen  in  WORD_WIDTH  number of kernel elements; sampled with start.
- busy  out  1  scan in progress.
- pair_valid  out  1  idx1/idx2 hold a matching pair.
- pair_ready  in  1  downstream accepts the pair.
- idx1  out  WORD_WIDTH  lower index of the matching pair.
- idx2  out  WORD_WIDTH  higher index of the matching pair.
- done  out  1  one-cycle pulse marking scan completion.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: w_we writes w_data to buffer[w_addr]. start=1 latches klen, clamped to MAX_KLEN, as N and sets i=0, j=1.
  - N ≥ 2: go to SCAN.
  - N < 2: go to DONE; no pairs are emitted.
- SCAN, each cycle: compare buffer[i] with buffer[j].
  - A match means equal values that are both non-zero.
  - The output slot is free when pair_valid=0, or when pair_valid=1 and pair_ready=1.
  - Match and slot free: load idx1=i, idx2=j, set pair_valid, advance.
  - Match and slot not free: stall; i and j are held.
  - No match: advance.
- Advance rule: j+1 if j < N-1; otherwise i+1, j=i+2.
  - The last pair is (N-2, N-1).
  - After the last pair is evaluated, go to DRAIN.
- DRAIN: wait until the slot is empty (no pair, or the pending pair is accepted this cycle), then go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- pair_valid drops when a pair is accepted and no new match is loaded in the same cycle.
- Pair order is lexicographic in (i, j). Every pair is emitted exactly once.
- Writes (w_we) while busy=1 are ignored. start while not in IDLE is ignored.
- Index arithmetic is unsigned WORD_WIDTH. N ≤ MAX_KLEN guarantees no wrap-around.

## Timing
- Reset values: busy=0, pair_valid=0, done=0, idx1=0, idx2=0; state IDLE. Buffer contents are retained (not cleared).
- Reset mid-scan: the next cycle is IDLE with all outputs at their reset values; any pending pair is dropped.
- start accepted at edge t: busy=1 from cycle t+1 through the done cycle, inclusive.
- Latency: the pair evaluated in cycle k shows pair_valid=1 in cycle k+1.
- Throughput: with pair_ready held at 1, one pair is evaluated per cycle.
  - First pair (0,1) is evaluated in cycle t+1; the last in cycle t + N(N-1)/2.
  - DRAIN lasts 1 cycle, then done pulses.
- Stalls: each cycle a match waits on the slot adds one cycle.
- idx1/idx2 are stable while pair_valid=1 and pair_ready=0.
- N < 2: done pulses in cycle t+1 with busy=1 in that cycle only.

## Structure
- Shared package redundancy_pkg holds:
  - the FSM state typedef (IDLE/SCAN/DRAIN/DONE);
  - the default WORD_WIDTH;
  - the ADDR_WIDTH derivation function.
- One sub-module, pair_index_counter, holds i/j, the advance rule, the last-pair flag and the N<2 check. It is enabled by the scanner's advance strobe.
- The weight buffer is an inline register array: one write port, two combinational read ports.

## Test plan
- Weights [3,5,3,7,5], klen=5, pair_ready=1 → pairs (0,2) then (1,4).
  - 10 evaluation cycles, 1 DRAIN cycle, done pulses 12 cycles after start.
- Weights [9,9,9,9], klen=4, pair_ready=1 → 6 consecutive pairs (0,1)…(2,3), one per cycle, with no gaps.
- Same as the 4-weight case with pair_ready=0 for 5 cycles after the first pair:
  - (0,1) is held stable for those 5 cycles;
  - no pair is lost or duplicated;
  - done is delayed by 5 cycles.
- Weights [0,0,4,4], klen=4 → only (2,3) is emitted; the zero-zero pair is not.
- klen=1 → no pair_valid, done pulses 1 cycle after start. klen=40 → clamped to 16: 120 pairs evaluated.
- Reset asserted while pair_valid=1 is held with pair_ready=0:
  - next cycle, all outputs are 0 and the FSM is in IDLE;
  - a rescan without reloading weights reproduces the same pair sequence.
- start and w_we pulsed while busy → both are ignored; the pair sequence is unchanged.

Source files
------------

// File: rtl/redundancy_pair_scanner_pkg.sv
// Shared types and helpers for the redundancy pair scanner.
package redundancy_pkg;

    localparam int DEFAULT_WORD_WIDTH = 8;
    localparam int DEFAULT_MAX_KLEN   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // Width of a write address into a buffer of the given depth (at least 1 bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/redundancy_pair_scanner_if.sv
// Pair output stream towards the distance calculator: valid/ready plus the index pair.
interface redundancy_pair_scanner_if #(
    parameter int WORD_WIDTH = redundancy_pkg::DEFAULT_WORD_WIDTH
);
    logic                  pair_valid;
    logic                  pair_ready;
    logic [WORD_WIDTH-1:0] idx1;
    logic [WORD_WIDTH-1:0] idx2;

    modport master (output pair_valid, output idx1, output idx2, input pair_ready);
    modport slave  (input pair_valid, input idx1, input idx2, output pair_ready);
endinterface

// File: rtl/redundancy_pair_scanner_pair_index_counter.sv
// Walks (i, j) over all index pairs i < j < N in lexicographic order.
module pair_index_counter
    import redundancy_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int MAX_KLEN   = DEFAULT_MAX_KLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  adv,
    input  logic [WORD_WIDTH-1:0] klen,
    output logic [WORD_WIDTH-1:0] i,
    output logic [WORD_WIDTH-1:0] j,
    output logic                  last_pair,
    output logic                  short_kernel
);

    localparam logic [WORD_WIDTH-1:0] KLEN_MAX = WORD_WIDTH'(MAX_KLEN);

    logic [WORD_WIDTH-1:0] n_q;
    logic [WORD_WIDTH-1:0] n_in;

    // Requested length clamped to the buffer depth; kernels below two elements have no pairs.
    assign n_in         = (klen > KLEN_MAX) ? KLEN_MAX : klen;
    assign short_kernel = (n_in < WORD_WIDTH'(2));
    assign last_pair    = (i == n_q - WORD_WIDTH'(2)) && (j == n_q - WORD_WIDTH'(1));

    // Latch N on load, then step j along the row and wrap to the next row at its end.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (reset) begin
            n_q <= '0;
            i   <= '0;
            j   <= '0;
        end else if (load) begin
            n_q <= n_in;
            i   <= '0;
            j   <= WORD_WIDTH'(1);
        end else if (adv) begin
            if (j < n_q - WORD_WIDTH'(1)) begin
                j <= j + WORD_WIDTH'(1);
            end else begin
                i <= i + WORD_WIDTH'(1);
                j <= i + WORD_WIDTH'(2);
            end
        end
    end

endmodule

// File: rtl/redundancy_pair_scanner.sv
// Finds pairs of equal non-zero weights in a loaded kernel and streams their indices.
module redundancy_pair_scanner
    import redundancy_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int MAX_KLEN   = DEFAULT_MAX_KLEN,
    parameter int ADDR_WIDTH = addr_width(MAX_KLEN)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   w_we,
    input  logic [ADDR_WIDTH-1:0]  w_addr,
    input  logic [WORD_WIDTH-1:0]  w_data,
    input  logic                   start,
    input  logic [WORD_WIDTH-1:0]  klen,
    output logic                   busy,
    output logic                   done,
    redundancy_pair_scanner_if.master pair
);

    scan_state_t state_q;
    scan_state_t state_d;

    logic [WORD_WIDTH-1:0] weights [MAX_KLEN];
    logic [WORD_WIDTH-1:0] i;
    logic [WORD_WIDTH-1:0] j;
    logic [WORD_WIDTH-1:0] w_i;
    logic [WORD_WIDTH-1:0] w_j;
    logic                  last_pair;
    logic                  short_kernel;
    logic                  counter_load;
    logic                  counter_adv;
    logic                  load_pair;
    logic                  match;
    logic                  slot_free;

    pair_index_counter #(
        .WORD_WIDTH (WORD_WIDTH),
        .MAX_KLEN   (MAX_KLEN)
    ) u_counter (
        .clk          (clk),
        .reset        (reset),
        .load         (counter_load),
        .adv          (counter_adv),
        .klen         (klen),
        .i            (i),
        .j            (j),
        .last_pair    (last_pair),
        .short_kernel (short_kernel)
    );

    // Weight buffer write port; the kernel is frozen while a scan runs.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset, so kernels survive a reset and can be rescanned.
        if (w_we && state_q == IDLE) begin
            weights[w_addr] <= w_data;
        end
    end

    // Two combinational read ports feed the comparator.
    assign w_i       = weights[i[ADDR_WIDTH-1:0]];
    assign w_j       = weights[j[ADDR_WIDTH-1:0]];
    assign match     = (w_i == w_j) && (w_i != '0);
    assign slot_free = !pair.pair_valid || pair.pair_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and scan control strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        counter_load = 1'b0;
        counter_adv  = 1'b0;
        load_pair    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    counter_load = 1'b1;
                    state_d      = short_kernel ? DONE : SCAN;
                end
            end
            SCAN: begin
                // A match that cannot be placed holds (i, j) until the slot frees.
                if (!(match && !slot_free)) begin
                    counter_adv = 1'b1;
                    load_pair   = match;
                    if (last_pair) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (slot_free) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output slot: load a new pair, or clear it once the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pair.pair_valid <= 1'b0;
            pair.idx1       <= '0;
            pair.idx2       <= '0;
        end else if (load_pair) begin
            pair.pair_valid <= 1'b1;
            pair.idx1       <= i;
            pair.idx2       <= j;
        end else if (pair.pair_ready) begin
            pair.pair_valid <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_redundancy_pair_scanner.sv
// Directed bench for redundancy_pair_scanner with a pair-list reference model.
module tb_redundancy_pair_scanner;
    import redundancy_pkg::*;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       w_we = 1'b0;
    logic [3:0] w_addr = '0;
    logic [7:0] w_data = '0;
    logic       start = 1'b0;
    logic [7:0] klen = '0;
    logic       busy;
    logic       done;

    redundancy_pair_scanner_if #(.WORD_WIDTH(8)) pair_bus ();

    redundancy_pair_scanner dut (
        .clk    (clk),
        .reset  (reset),
        .w_we   (w_we),
        .w_addr (w_addr),
        .w_data (w_data),
        .start  (start),
        .klen   (klen),
        .busy   (busy),
        .done   (done),
        .pair   (pair_bus)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    bit    score_en = 1'b0;
    pair_t exp_q[$];
    logic [7:0] shadow [16];

    logic [7:0] ker_a [5] = '{8'd3, 8'd5, 8'd3, 8'd7, 8'd5};
    logic [7:0] ker_b [4] = '{8'd9, 8'd9, 8'd9, 8'd9};
    logic [7:0] ker_d [4] = '{8'd0, 8'd0, 8'd4, 8'd4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: every (a, b) with a < b < N whose weights are equal and non-zero.
    task automatic build_expected(input int kl, output int count);
        int n;
        n = (kl > 16) ? 16 : kl;
        count = 0;
        exp_q.delete();
        for (int a = 0; a < n; a++) begin
            for (int b = a + 1; b < n; b++) begin
                if (shadow[a] == shadow[b] && shadow[a] != 8'd0) begin
                    exp_q.push_back('{a: 8'(a), b: 8'(b)});
                    count++;
                end
            end
        end
    endtask

    task automatic write_w(input int addr, input logic [7:0] val);
        @(posedge clk); #1;
        w_we = 1'b1;
        w_addr = 4'(addr);
        w_data = val;
        shadow[addr] = val;
        @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    // Start a scan and run it to done; cycle k is the k-th cycle after the start edge.
    task automatic run_scan(input string name, input int kl, input int stall_len,
                            input int poke_k, input int exp_done, input int exp_pairs);
        int    cnt;
        int    done_k;
        int    busy_bad;
        int    stall_left;
        bit    seen_first;
        build_expected(kl, cnt);
        check({name, " model pair count"}, cnt, exp_pairs);
        done_k = -1;
        busy_bad = 0;
        stall_left = 0;
        seen_first = 1'b0;
        score_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        klen = 8'(kl);
        pair_bus.pair_ready = 1'b1;
        for (int k = 1; k <= exp_done + 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            w_we = 1'b0;
            if (stall_len > 0 && !seen_first && pair_bus.pair_valid) begin
                seen_first = 1'b1;
                stall_left = stall_len;
            end
            pair_bus.pair_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (k == poke_k) begin
                start = 1'b1;
                klen = 8'd2;
                w_we = 1'b1;
                w_addr = 4'd1;
                w_data = 8'd3;
            end
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        check({name, " done cycle"}, 32'(done_k), 32'(exp_done));
        check({name, " pairs left unemitted"}, 32'(exp_q.size()), 32'd0);
        check({name, " busy dropped early"}, 32'(busy_bad), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, " idle after done {busy,done}"}, {30'd0, busy, done}, 32'd0);
        score_en = 1'b0;
    endtask

    // Compare process: each accepted pair must be the next one the model predicts,
    // and a pair waiting on pair_ready must not change.
    logic  prev_hold = 1'b0;
    pair_t prev_pair;
    always @(negedge clk) begin
        if (!score_en || reset) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                check("held pair valid", {31'd0, pair_bus.pair_valid}, 32'd1);
                check("held pair stable", {16'd0, pair_bus.idx1, pair_bus.idx2}, {16'd0, prev_pair});
            end
            if (pair_bus.pair_valid && pair_bus.pair_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected extra pair", {16'd0, pair_bus.idx1, pair_bus.idx2}, 32'hffff_ffff);
                end else begin
                    check("pair order", {16'd0, pair_bus.idx1, pair_bus.idx2}, {16'd0, exp_q.pop_front()});
                end
            end
            prev_hold <= pair_bus.pair_valid && !pair_bus.pair_ready;
            prev_pair <= '{a: pair_bus.idx1, b: pair_bus.idx2};
        end
    end

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        pair_bus.pair_ready = 1'b1;
        foreach (shadow[x]) shadow[x] = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset pair_valid", {31'd0, pair_bus.pair_valid}, 32'd0);
        check("reset idx", {16'd0, pair_bus.idx1, pair_bus.idx2}, 32'd0);
        check("reset state", 32'(dut.state_q), 32'(IDLE));

        // Clear the whole buffer so stale entries never pair up.
        for (int x = 0; x < 16; x++) write_w(x, 8'd0);

        // [3,5,3,7,5]: (0,2) then (1,4); done 12 cycles after start.
        foreach (ker_a[x]) write_w(x, ker_a[x]);
        build_expected(5, cnt);
        check("model A first pair", {16'd0, exp_q[0]}, 32'h0002);
        check("model A second pair", {16'd0, exp_q[1]}, 32'h0104);
        run_scan("A", 5, 0, 0, 12, 2);

        // [9,9,9,9]: six back-to-back pairs, done at 6 + 2.
        foreach (ker_b[x]) write_w(x, ker_b[x]);
        run_scan("B", 4, 0, 0, 8, 6);

        // Same kernel with the first pair held for 5 cycles: done 5 cycles later.
        run_scan("B stall", 4, 5, 0, 13, 6);

        // [0,0,4,4]: zero-zero pair suppressed, only (2,3).
        foreach (ker_d[x]) write_w(x, ker_d[x]);
        build_expected(4, cnt);
        check("model D only pair", {16'd0, exp_q[0]}, 32'h0203);
        run_scan("D", 4, 0, 0, 8, 1);

        // Short kernels finish one cycle after start.
        run_scan("klen1", 1, 0, 0, 1, 0);
        run_scan("klen0", 0, 0, 0, 1, 0);

        // klen=40 clamps to 16; all-equal weights give 120 pairs, done at 122.
        for (int x = 0; x < 16; x++) write_w(x, 8'd7);
        run_scan("klen40", 40, 0, 0, 122, 120);

        // Reset while a pair is held, then rescan the retained kernel.
        for (int x = 0; x < 16; x++) write_w(x, 8'd0);
        foreach (ker_b[x]) write_w(x, ker_b[x]);
        score_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        klen = 8'd4;
        pair_bus.pair_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre-reset pair held", {31'd0, pair_bus.pair_valid}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid-scan reset outputs", {13'd0, busy, done, pair_bus.pair_valid, pair_bus.idx1, pair_bus.idx2}, 32'd0);
        check("mid-scan reset state", 32'(dut.state_q), 32'(IDLE));
        pair_bus.pair_ready = 1'b1;
        run_scan("rescan after reset", 4, 0, 0, 8, 6);

        // start and a write poked mid-scan must both be ignored.
        foreach (ker_a[x]) write_w(x, ker_a[x]);
        run_scan("poke while busy", 5, 0, 3, 12, 2);
        run_scan("after poke", 5, 0, 0, 12, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
